flappy_game_ctrl: RTL and testbench

- Game-sequencing controller for the Flappy Bird VGA design.
- Once per video frame it steps bird physics, commands the pipe generator to scroll, checks collision, and keeps the score.
- Sits between the VGA timing generator (frame_tick), the input logic (flap button, pause switch), the pipe generator (pipe_x, gap_y) and the renderer and 7-segment display (bird_y, state, score_bcd).

---
 rtl/flappy_pkg.sv | 37 +++
 rtl/flappy_game_ctrl_if.sv | 31 +++
 rtl/bcd4_counter.sv | 49 ++++
 rtl/flappy_game_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// flappy_pkg : shared game states, frame-sequence phases, geometry and physics
// Rev 1.0
// ============================================================================
package flappy_pkg;

    localparam int SCREEN_H = 480;
    localparam int GROUND_H = 40;
    localparam int BIRD_X   = 160;
    localparam int BIRD_W   = 16;
    localparam int BIRD_H   = 16;
    localparam int PIPE_W   = 52;
    localparam int GAP_H    = 120;
    localparam int START_Y  = 232;
    localparam int FLOOR_Y  = SCREEN_H - GROUND_H - BIRD_H;

    localparam int GRAVITY  = 1;
    localparam int FLAP_VEL = -8;
    localparam int VMAX     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_MOVE   = 2'd1,
        SEQ_SETTLE = 2'd2,
        SEQ_CHECK  = 2'd3
    } frame_seq_e;

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/flappy_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// flappy_game_ctrl_if : controller <-> VGA/input/pipe/renderer signal bundle
// Rev 1.0
// ============================================================================
interface flappy_game_ctrl_if;

    logic        frame_tick;
    logic        flap;
    logic        pause;
    logic [9:0]  pipe_x;
    logic [8:0]  gap_y;
    logic        pipe_step;
    logic        pipe_rst;
    logic [8:0]  bird_y;
    logic [1:0]  state;
    logic [15:0] score_bcd;
    logic        game_over;

    modport master (
        output frame_tick, flap, pause, pipe_x, gap_y,
        input  pipe_step, pipe_rst, bird_y, state, score_bcd, game_over
    );

    modport slave (
        input  frame_tick, flap, pause, pipe_x, gap_y,
        output pipe_step, pipe_rst, bird_y, state, score_bcd, game_over
    );

endinterface : flappy_game_ctrl_if
`default_nettype wire

// File: rtl/bcd4_counter.sv
`default_nettype none
// ============================================================================
// bcd4_counter : 4-digit BCD up-counter, saturating at 9999, sync clear
// Rev 1.0
// ============================================================================
module bcd4_counter (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        inc_i,
    input  wire logic        clr_i,
    output logic      [15:0] bcd_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        carry;

    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != 16'h9999)) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (cnt_q[4*i +: 4] == 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bcd_o = cnt_q;

endmodule : bcd4_counter
`default_nettype wire

// File: rtl/flappy_game_ctrl.sv
`default_nettype none
// ============================================================================
// flappy_game_ctrl : per-frame bird physics, pipe scroll, collision and score
// Rev 1.0
// ============================================================================
module flappy_game_ctrl
    import flappy_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    flappy_game_ctrl_if.slave ctrl
);

    localparam logic signed [5:0]  c_grav     = 6'(GRAVITY);
    localparam logic signed [5:0]  c_flap_vel = 6'(FLAP_VEL);
    localparam logic signed [5:0]  c_vmax     = 6'(VMAX);
    localparam logic signed [10:0] c_floor_s  = 11'(FLOOR_Y);
    localparam logic        [8:0]  c_floor_y  = 9'(FLOOR_Y);
    localparam logic        [8:0]  c_start_y  = 9'(START_Y);
    localparam logic        [10:0] c_bird_l   = 11'(BIRD_X);
    localparam logic        [10:0] c_bird_r   = 11'(BIRD_X + BIRD_W);
    localparam logic        [10:0] c_bird_h   = 11'(BIRD_H);
    localparam logic        [10:0] c_pipe_w   = 11'(PIPE_W);
    localparam logic        [10:0] c_gap_h    = 11'(GAP_H);

    game_state_e       state_q,    state_d;
    frame_seq_e        seq_q,      seq_d;
    logic        [8:0] bird_y_q,   bird_y_d;
    logic signed [5:0] vel_q,      vel_d;
    logic              pending_q,  pending_d;
    logic              scored_q,   scored_d;
    logic              floor_q,    floor_d;
    logic              launch_q,   launch_d;
    logic              pipe_rst_q, pipe_rst_d;
    logic              flap_prev_q;

    logic              score_inc;
    logic              score_clr;
    logic [15:0]       score_bcd;

    logic              w_flap_edge;
    logic              w_running;
    logic signed [5:0] w_vel_sum;
    logic signed [5:0] w_vel_grav;
    logic signed [5:0] w_vel_new;
    logic signed [10:0] w_y_new;
    logic [10:0]       w_px, w_px_end, w_by_top, w_by_bot, w_gap_top, w_gap_bot;
    logic              w_overlap, w_miss, w_passed, w_wrapped;

    assign w_flap_edge = ctrl.flap & ~flap_prev_q;
    assign w_running   = (state_q == ST_PLAY) || (state_q == ST_DYING);

    // The start flap's velocity is used as-is on the first frame (no gravity).
    assign w_vel_sum  = vel_q + c_grav;
    assign w_vel_grav = (w_vel_sum > c_vmax) ? c_vmax : w_vel_sum;
    assign w_vel_new  = ((state_q == ST_PLAY) && (pending_q || launch_q)) ? c_flap_vel : w_vel_grav;
    assign w_y_new    = $signed({2'b00, bird_y_q}) + 11'(w_vel_new);

    assign w_px      = {1'b0, ctrl.pipe_x};
    assign w_px_end  = w_px + c_pipe_w;
    assign w_by_top  = {2'b00, bird_y_q};
    assign w_by_bot  = w_by_top + c_bird_h;
    assign w_gap_top = {2'b00, ctrl.gap_y};
    assign w_gap_bot = w_gap_top + c_gap_h;
    assign w_overlap = (w_px < c_bird_r) && (w_px_end > c_bird_l);
    assign w_miss    = (w_by_top < w_gap_top) || (w_by_bot > w_gap_bot);
    assign w_passed  = (w_px_end <= c_bird_l);
    assign w_wrapped = (w_px > c_bird_r);

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        bird_y_d   = bird_y_q;
        vel_d      = vel_q;
        pending_d  = 1'b0;
        scored_d   = scored_q;
        floor_d    = floor_q;
        launch_d   = launch_q;
        pipe_rst_d = 1'b0;
        score_inc  = 1'b0;
        score_clr  = 1'b0;
        if (!ctrl.pause) begin
            unique case (seq_q)
                SEQ_IDLE: begin
                    if (ctrl.frame_tick && w_running) begin
                        seq_d = SEQ_MOVE;
                    end
                end
                SEQ_MOVE: begin
                    seq_d    = SEQ_SETTLE;
                    launch_d = 1'b0;
                    if (w_y_new[10]) begin
                        bird_y_d = '0;
                        vel_d    = '0;
                        floor_d  = 1'b0;
                    end else if (w_y_new >= c_floor_s) begin
                        bird_y_d = c_floor_y;
                        vel_d    = w_vel_new;
                        floor_d  = 1'b1;
                    end else begin
                        bird_y_d = w_y_new[8:0];
                        vel_d    = w_vel_new;
                        floor_d  = 1'b0;
                    end
                end
                SEQ_SETTLE: begin
                    seq_d = SEQ_CHECK;
                end
                SEQ_CHECK: begin
                    seq_d   = SEQ_IDLE;
                    floor_d = 1'b0;
                    if (floor_q) begin
                        state_d = ST_OVER;
                    end else if (state_q == ST_PLAY) begin
                        if (w_overlap && w_miss) begin
                            state_d = ST_DYING;
                        end else if (w_passed && !scored_q) begin
                            score_inc = 1'b1;
                            scored_d  = 1'b1;
                        end else if (w_wrapped) begin
                            scored_d  = 1'b0;
                        end
                    end
                end
                default: seq_d = SEQ_IDLE;
            endcase

            if ((state_q == ST_IDLE) && w_flap_edge) begin
                state_d  = ST_PLAY;
                vel_d    = c_flap_vel;
                launch_d = 1'b1;
            end else if ((state_q == ST_OVER) && w_flap_edge) begin
                state_d    = ST_IDLE;
                bird_y_d   = c_start_y;
                vel_d      = '0;
                scored_d   = 1'b0;
                launch_d   = 1'b0;
                score_clr  = 1'b1;
                pipe_rst_d = 1'b1;
            end

            // A flap edge on the MOVE cycle itself is kept for the next frame.
            if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
                pending_d = w_flap_edge | (pending_q & (seq_q != SEQ_MOVE));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            seq_q       <= SEQ_IDLE;
            bird_y_q    <= c_start_y;
            vel_q       <= '0;
            pending_q   <= 1'b0;
            scored_q    <= 1'b0;
            floor_q     <= 1'b0;
            launch_q    <= 1'b0;
            pipe_rst_q  <= 1'b0;
            flap_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            pending_q   <= pending_d;
            scored_q    <= scored_d;
            floor_q     <= floor_d;
            launch_q    <= launch_d;
            pipe_rst_q  <= pipe_rst_d;
            flap_prev_q <= ctrl.flap;
        end
    end

    bcd4_counter u_score (
        .clk   (clk),
        .rst   (rst),
        .inc_i (score_inc),
        .clr_i (score_clr),
        .bcd_o (score_bcd)
    );

    assign ctrl.pipe_step = (seq_q == SEQ_MOVE) && (state_q == ST_PLAY) && !ctrl.pause;
    assign ctrl.pipe_rst  = pipe_rst_q;
    assign ctrl.bird_y    = bird_y_q;
    assign ctrl.state     = state_q;
    assign ctrl.score_bcd = score_bcd;
    assign ctrl.game_over = (state_q == ST_OVER);

endmodule : flappy_game_ctrl
`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_flappy_game_ctrl : directed self-checking bench for flappy_game_ctrl
// Rev 1.0
// ============================================================================
module tb_flappy_game_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flappy_game_ctrl_if bus ();

    flappy_game_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   frames;
    logic step_first;
    logic step_extra;
    logic step_any;
    logic rst_any;
    logic saw_dying;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after CHECK has completed.
    task automatic frame(input logic fl);
        step_first     = 1'b0;
        step_extra     = bus.pipe_step;
        bus.frame_tick = 1'b1;
        bus.flap       = fl;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;
        step_first     = bus.pipe_step;
        repeat (3) begin
            @(negedge clk);
            step_extra = step_extra | bus.pipe_step;
        end
    endtask

    task automatic flap_edge();
        bus.flap = 1'b1;
        @(negedge clk);
        bus.flap = 1'b0;
    endtask

    task automatic paused_activity();
        bus.pause = 1'b1;
        step_any  = 1'b0;
        rst_any   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.frame_tick = ((i % 4) == 0);
            bus.flap       = ((i % 2) == 0);
            @(negedge clk);
            step_any = step_any | bus.pipe_step;
            rst_any  = rst_any | bus.pipe_rst;
        end
        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;
        @(negedge clk);
        bus.pause = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.flap       = 1'b0;
        bus.pause      = 1'b0;
        bus.pipe_x     = 10'd400;
        bus.gap_y      = 9'd200;
        repeat (3) @(negedge clk);
        chk("rst_state",  32'(bus.state),     32'd0);
        chk("rst_y",      32'(bus.bird_y),    32'd232);
        chk("rst_score",  32'(bus.score_bcd), 32'h0);
        chk("rst_step",   32'(bus.pipe_step), 32'd0);
        chk("rst_prst",   32'(bus.pipe_rst),  32'd0);
        chk("rst_over",   32'(bus.game_over), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ticks in IDLE do nothing
        step_any = 1'b0;
        repeat (5) begin
            frame(1'b0);
            step_any = step_any | step_first | step_extra;
        end
        chk("idle_state", 32'(bus.state),     32'd0);
        chk("idle_y",     32'(bus.bird_y),    32'd232);
        chk("idle_step",  32'(step_any),      32'd0);
        chk("idle_score", 32'(bus.score_bcd), 32'h0);

        // Start and fall
        flap_edge();
        chk("start_state", 32'(bus.state),  32'd1);
        chk("start_y",     32'(bus.bird_y), 32'd232);
        frame(1'b0);
        chk("fall_y1",     32'(bus.bird_y), 32'd224);
        chk("fall_step1",  32'(step_first), 32'd1);
        chk("fall_extra1", 32'(step_extra), 32'd0);
        frame(1'b0);
        chk("fall_y2",     32'(bus.bird_y), 32'd217);
        chk("fall_step2",  32'(step_first), 32'd1);
        frame(1'b0);
        chk("fall_y3",     32'(bus.bird_y), 32'd211);
        chk("fall_extra3", 32'(step_extra), 32'd0);

        // Scoring through the gap
        bus.gap_y  = 9'd200;
        bus.pipe_x = 10'd120; frame(1'b0);
        chk("sc_y120",     32'(bus.bird_y), 32'd206);
        bus.pipe_x = 10'd113; frame(1'b0);
        chk("sc_state113", 32'(bus.state),  32'd1);
        bus.pipe_x = 10'd106; frame(1'b0);
        chk("sc_one",      32'(bus.score_bcd), 32'h0001);
        chk("sc_y106",     32'(bus.bird_y),    32'd199);
        bus.pipe_x = 10'd104; frame(1'b0);
        chk("sc_once",     32'(bus.score_bcd), 32'h0001);
        bus.pipe_x = 10'd640; frame(1'b0);
        bus.pipe_x = 10'd106; frame(1'b0);
        chk("sc_two",      32'(bus.score_bcd), 32'h0002);
        chk("sc_y_two",    32'(bus.bird_y),    32'd196);

        // Saturation at 9999
        force dut.u_score.cnt_q = 16'h9999;
        repeat (2) @(negedge clk);
        release dut.u_score.cnt_q;
        bus.pipe_x = 10'd640; frame(1'b0);
        bus.pipe_x = 10'd106; frame(1'b0);
        chk("sat_score", 32'(bus.score_bcd), 32'h9999);
        chk("sat_y",     32'(bus.bird_y),    32'd199);

        // Ceiling clamp
        bus.pipe_x = 10'd400;
        frame(1'b1);
        chk("ceil_y1", 32'(bus.bird_y), 32'd191);
        repeat (25) frame(1'b1);
        chk("ceil_y",     32'(bus.bird_y), 32'd0);
        chk("ceil_state", 32'(bus.state),  32'd1);

        // Pipe hit then fall to the floor while dying
        bus.pipe_x = 10'd150;
        bus.gap_y  = 9'd300;
        frame(1'b0);
        chk("hit_state", 32'(bus.state),  32'd2);
        chk("hit_y",     32'(bus.bird_y), 32'd1);
        frames   = 0;
        step_any = 1'b0;
        while ((bus.state == 2'd2) && (frames < 60)) begin
            frame(frames[0]);
            frames++;
            step_any = step_any | step_first | step_extra;
        end
        chk("die_frames", 32'(frames),        32'd46);
        chk("die_state",  32'(bus.state),     32'd3);
        chk("die_y",      32'(bus.bird_y),    32'd424);
        chk("die_over",   32'(bus.game_over), 32'd1);
        chk("die_step",   32'(step_any),      32'd0);
        chk("die_score",  32'(bus.score_bcd), 32'h9999);

        // Pause in OVER freezes everything, including restart
        paused_activity();
        chk("pov_state", 32'(bus.state),     32'd3);
        chk("pov_y",     32'(bus.bird_y),    32'd424);
        chk("pov_score", 32'(bus.score_bcd), 32'h9999);
        chk("pov_prst",  32'(rst_any),       32'd0);

        // Restart
        flap_edge();
        chk("rs_prst",  32'(bus.pipe_rst),  32'd1);
        chk("rs_state", 32'(bus.state),     32'd0);
        chk("rs_y",     32'(bus.bird_y),    32'd232);
        chk("rs_score", 32'(bus.score_bcd), 32'h0);
        chk("rs_over",  32'(bus.game_over), 32'd0);
        @(negedge clk);
        chk("rs_prst_off", 32'(bus.pipe_rst), 32'd0);

        // New game: pause mid-play, then no flaps down to the floor
        bus.pipe_x = 10'd400;
        bus.gap_y  = 9'd200;
        flap_edge();
        chk("g2_state", 32'(bus.state), 32'd1);
        repeat (3) frame(1'b0);
        chk("g2_y3", 32'(bus.bird_y), 32'd211);
        paused_activity();
        chk("pp_step",  32'(step_any),   32'd0);
        chk("pp_y",     32'(bus.bird_y), 32'd211);
        chk("pp_state", 32'(bus.state),  32'd1);
        frame(1'b0);
        chk("pp_resume_y", 32'(bus.bird_y), 32'd206);
        frames    = 4;
        saw_dying = 1'b0;
        while ((bus.state == 2'd1) && (frames < 60)) begin
            frame(1'b0);
            frames++;
            if (bus.state == 2'd2) saw_dying = 1'b1;
        end
        chk("fl_frames", 32'(frames),    32'd37);
        chk("fl_state",  32'(bus.state), 32'd3);
        chk("fl_y",      32'(bus.bird_y), 32'd424);
        chk("fl_dying",  32'(saw_dying), 32'd0);

        // Reset in the middle of a frame sequence
        flap_edge();
        @(negedge clk);
        flap_edge();
        chk("g3_state", 32'(bus.state), 32'd1);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        chk("mid_y", 32'(bus.bird_y), 32'd224);
        rst = 1'b1;
        #1;
        chk("mrst_state", 32'(bus.state),     32'd0);
        chk("mrst_y",     32'(bus.bird_y),    32'd232);
        chk("mrst_step",  32'(bus.pipe_step), 32'd0);
        step_any = 1'b0;
        repeat (3) begin
            @(negedge clk);
            step_any = step_any | bus.pipe_step;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            step_any = step_any | bus.pipe_step;
        end
        chk("mrst_nostep",  32'(step_any),  32'd0);
        chk("mrst_state2",  32'(bus.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_flappy_game_ctrl
`default_nettype wire
